// File: rtl/scarv_cop_dispatch_if.sv
// Bundle of CPU instruction, decoder and functional-unit signals around the
// coprocessor dispatch stage. slave = dispatch stage, master = its environment.
interface scarv_cop_dispatch_if;
  // CPU instruction request
  logic        cpu_insn_req;
  logic        cpu_insn_ack;
  logic [31:0] cpu_insn_enc;
  logic [31:0] cpu_rs1;
  // CPU response
  logic        cpu_insn_rsp_valid;
  logic        cpu_insn_rsp_ack;
  logic [2:0]  cpu_insn_rsp_status;
  logic [4:0]  cpu_insn_rsp_rd;
  logic        cpu_insn_rsp_wen;
  logic [31:0] cpu_insn_rsp_wdata;
  // decoder
  logic [31:0] id_encoded;
  logic        id_exception;
  logic [3:0]  id_class;
  logic [4:0]  id_rd;
  // functional units
  logic [15:0] fu_req;
  logic [31:0] fu_rs1;
  logic        fu_done;
  logic [2:0]  fu_status;
  logic        fu_gpr_wen;
  logic [31:0] fu_gpr_wdata;

  modport slave (
    input  cpu_insn_req, cpu_insn_enc, cpu_rs1, cpu_insn_rsp_ack,
           id_exception, id_class, id_rd,
           fu_done, fu_status, fu_gpr_wen, fu_gpr_wdata,
    output cpu_insn_ack, cpu_insn_rsp_valid, cpu_insn_rsp_status,
           cpu_insn_rsp_rd, cpu_insn_rsp_wen, cpu_insn_rsp_wdata,
           id_encoded, fu_req, fu_rs1
  );

  modport master (
    output cpu_insn_req, cpu_insn_enc, cpu_rs1, cpu_insn_rsp_ack,
           id_exception, id_class, id_rd,
           fu_done, fu_status, fu_gpr_wen, fu_gpr_wdata,
    input  cpu_insn_ack, cpu_insn_rsp_valid, cpu_insn_rsp_status,
           cpu_insn_rsp_rd, cpu_insn_rsp_wen, cpu_insn_rsp_wdata,
           id_encoded, fu_req, fu_rs1
  );
endinterface

// File: rtl/scarv_cop_dispatch.sv
// Single-outstanding coprocessor issue stage: accept, decode, dispatch to one
// functional unit, then hold the response until the CPU acknowledges it.
module scarv_cop_dispatch #(
  parameter logic [15:0] CLASS_EN = 16'h03FF,
  parameter int          TIMEOUT  = 64,
  parameter int          CNT_W    = 8
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  scarv_cop_dispatch_if.slave  bus,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [2:0]  status;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] wdata;
  } rsp_t;

  localparam logic [2:0] ST_ILLEGAL = 3'd1;
  localparam logic [2:0] ST_TIMEOUT = 3'd7;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state, nxt;
  rsp_t             rsp;
  logic [CNT_W-1:0] cnt;
  logic             legal;
  logic             timeout_hit;

  // Decoder outputs are only meaningful in DECODE, where they reflect id_encoded.
  assign legal       = !bus.id_exception && CLASS_EN[bus.id_class];
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state <= S_IDLE;
    else           state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (bus.cpu_insn_req) nxt = S_DECODE;
      S_DECODE: nxt = legal ? S_WAIT : S_RESP;
      S_WAIT:   if (bus.fu_done || timeout_hit) nxt = S_RESP;
      S_RESP:   if (bus.cpu_insn_rsp_ack) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      bus.id_encoded <= '0;
      bus.fu_rs1     <= '0;
      bus.fu_req     <= '0;
      rsp            <= '0;
      cnt            <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.cpu_insn_req) begin
            bus.id_encoded <= bus.cpu_insn_enc;
            bus.fu_rs1     <= bus.cpu_rs1;
          end
        end
        S_DECODE: begin
          rsp.rd <= bus.id_rd;
          if (!legal) begin
            rsp.status <= ST_ILLEGAL;
            rsp.wen    <= 1'b0;
            rsp.wdata  <= '0;
          end else begin
            bus.fu_req <= 16'b1 << bus.id_class;
            cnt        <= '0;
          end
        end
        S_WAIT: begin
          // A completion in the expiry cycle still wins over the timeout.
          if (bus.fu_done) begin
            rsp.status <= bus.fu_status;
            rsp.wen    <= bus.fu_gpr_wen;
            rsp.wdata  <= bus.fu_gpr_wdata;
            bus.fu_req <= '0;
          end else if (timeout_hit) begin
            rsp.status <= ST_TIMEOUT;
            rsp.wen    <= 1'b0;
            rsp.wdata  <= '0;
            bus.fu_req <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_insn_ack        = (state == S_IDLE) && bus.cpu_insn_req;
  assign bus.cpu_insn_rsp_valid  = (state == S_RESP);
  assign bus.cpu_insn_rsp_status = rsp.status;
  assign bus.cpu_insn_rsp_rd     = rsp.rd;
  // x0 is hardwired to zero, so never ask the CPU to write it.
  assign bus.cpu_insn_rsp_wen    = rsp.wen && (rsp.rd != 5'd0);
  assign bus.cpu_insn_rsp_wdata  = rsp.wdata;
  assign busy                    = (state != S_IDLE);

endmodule
